// File: rtl/byte_enable_memory.sv
// ---------------------------------------------------------------------------
// byte_enable_memory
//
// Single-port synchronous data memory for the core's memory stage. Requests
// arrive over a valid/ready handshake; writes update only the byte lanes
// selected by req_be, and reads return data READ_LATENCY cycles after the
// accepting edge. After reset, and after a soft-clear pulse, the block walks
// the whole array writing zeros before it accepts any request.
//
// Parameters:
//   DATA_WIDTH   - word width in bits (multiple of 8)
//   ADDR_WIDTH   - word address width, DEPTH = 2**ADDR_WIDTH
//   READ_LATENCY - cycles from accepted read to rsp_valid (1..4)
//
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-high reset
//   clr       - synchronous soft-clear request (one-cycle pulse)
//   req_valid - request present
//   req_ready - request can be accepted this cycle
//   req_we    - 1 = write, 0 = read
//   req_addr  - word address
//   req_be    - byte-lane write enables, bit i covers bits [8i+7:8i]
//   req_wdata - write data
//   rsp_valid - read data valid, one pulse per read
//   rsp_rdata - read data, held between responses
//   init_done - high once the array has been cleared
// ---------------------------------------------------------------------------
module byte_enable_memory #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    init_done
);

    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    accept_write;
    logic                    accept_read;
    logic [READ_LATENCY-1:0] pipe_valid;
    logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];

    // A soft-clear pulse takes priority over any pending request, so ready
    // drops combinationally in the same cycle clr is seen; the requester
    // then simply keeps holding its request until the clear has finished.
    assign req_ready    = (state == ST_READY) && !clr;
    assign accept_write = req_valid && req_ready && req_we;
    assign accept_read  = req_valid && req_ready && !req_we;

    // Control state machine. CLEAR sweeps clr_cnt through every address
    // exactly once; the edge that writes the last word also hands over to
    // READY, and the counter naturally wraps back to zero for the next
    // sweep. In READY a clr pulse restarts the sweep on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == {ADDR_WIDTH{1'b1}}) begin
                        state     <= ST_READY;
                        init_done <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (clr) begin
                        state     <= ST_CLEAR;
                        clr_cnt   <= '0;
                        init_done <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

    // Array write port. The array itself has no reset so it can map onto
    // block RAM; zeroing is done by the CLEAR sweep instead. Because the
    // port is shared, sweep writes and request writes never coincide:
    // requests are only accepted in READY.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (accept_write) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (req_be[i]) begin
                    mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read pipeline. Stage 0 captures the array word on the accepting edge,
    // so a read that follows a write to the same address by one cycle sees
    // the new data. Each later stage only loads when the stage before it
    // holds a live read, which makes the final stage's data register keep
    // its last response while no read is completing. Reset flushes every
    // stage so in-flight reads never surface; a soft clear does not touch
    // the pipeline, so reads already issued return their pre-clear data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_data[k] <= '0;
            end
        end else begin
            pipe_valid[0] <= accept_read;
            if (accept_read) begin
                pipe_data[0] <= mem[req_addr];
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                if (pipe_valid[k-1]) begin
                    pipe_data[k] <= pipe_data[k-1];
                end
            end
        end
    end

    assign rsp_valid = pipe_valid[READ_LATENCY-1];
    assign rsp_rdata = pipe_data[READ_LATENCY-1];

endmodule

// File: tb/tb_byte_enable_memory.sv
// ---------------------------------------------------------------------------
// tb_byte_enable_memory
//
// Drives two copies of byte_enable_memory (read latency 1 and 3) from the
// same request stream. A reference model (a plain word array with byte-lane
// merging) predicts each read's data and the edge it must appear on; these
// predictions are queued per instance and a separate monitor compares them
// against whatever each instance presents on its response port.
// ---------------------------------------------------------------------------
module tb_byte_enable_memory;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          clr       = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we    = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [NB-1:0] req_be    = '0;
    logic [DW-1:0] req_wdata = '0;

    logic          rsp_v  [2];
    logic [DW-1:0] rsp_d  [2];
    logic          ready  [2];
    logic          done   [2];

    int            vectors     = 0;
    int            miscompares = 0;
    int            cyc         = 0;

    exp_t          expq [2][$];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] last_rsp [2];

    // Free-running clock and an edge counter used to timestamp responses.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    byte_enable_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (ready[0]),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_v[0]),
        .rsp_rdata (rsp_d[0]),
        .init_done (done[0])
    );

    byte_enable_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (ready[1]),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_v[1]),
        .rsp_rdata (rsp_d[1]),
        .init_done (done[1])
    );

    // Single comparison point: every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [DW-1:0] got,
                               input logic [DW-1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
        end
    endtask

    // Reference model: whole-array zeroing.
    task automatic modelClear();
        for (int a = 0; a < DEPTH; a++) begin
            ref_mem[a] = '0;
        end
    endtask

    // Reference model: reset wipes the array and discards outstanding reads.
    task automatic modelReset();
        modelClear();
        expq[0].delete();
        expq[1].delete();
        last_rsp[0] = '0;
        last_rsp[1] = '0;
    endtask

    // Reference model: an accepted request on edge accept_edge. Reads are
    // due accept_edge + latency - 1 in terms of the edge counter seen just
    // after that edge.
    task automatic modelAccept(input logic we, input logic [AW-1:0] addr,
                               input logic [NB-1:0] be, input logic [DW-1:0] wdata,
                               input int accept_edge);
        exp_t e;
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) ref_mem[addr][8*i +: 8] = wdata[8*i +: 8];
            end
        end else begin
            e.data = ref_mem[addr];
            e.due  = accept_edge;
            expq[0].push_back(e);
            e.due  = accept_edge + 2;
            expq[1].push_back(e);
        end
    endtask

    // Presents one request starting at a falling edge and holds it until
    // accepted; returns at the falling edge after the accepting edge.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr,
                                 input logic [NB-1:0] be, input logic [DW-1:0] wdata);
        bit accepted = 1'b0;
        int waited   = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_be    = be;
        req_wdata = wdata;
        while (!accepted && waited < 2 * DEPTH) begin
            #1;
            accepted = ready[0];
            if (accepted) modelAccept(we, addr, be, wdata, cyc + 1);
            @(negedge clk);
            waited++;
        end
        if (!accepted) checkOutput("req_accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts edges from start_edge until init_done rises, checking that
    // neither instance offers ready or init_done while clearing.
    task automatic waitInit(input string name, input int start_edge);
        int n      = 0;
        bit leaked = 1'b0;
        while (!done[0] && n < 4 * DEPTH) begin
            if (ready[0] || ready[1] || done[1]) leaked = 1'b1;
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_clear_cycles"}, cyc - start_edge, DEPTH);
        checkOutput({name, "_ready_low"}, {31'd0, leaked}, 32'd0);
        checkOutput({name, "_init_done_lat3"}, {31'd0, done[1]}, 32'd1);
    endtask

    task automatic checkResetOutputs(input string name);
        for (int p = 0; p < 2; p++) begin
            checkOutput($sformatf("%s_rsp_valid%0d", name, p), {31'd0, rsp_v[p]}, 32'd0);
            checkOutput($sformatf("%s_rsp_rdata%0d", name, p), rsp_d[p], 32'd0);
            checkOutput($sformatf("%s_init_done%0d", name, p), {31'd0, done[p]}, 32'd0);
            checkOutput($sformatf("%s_req_ready%0d", name, p), {31'd0, ready[p]}, 32'd0);
        end
    endtask

    // Response monitor, sampling 3 time units after each rising edge.
    // Every response must match the head of its instance's queue in both
    // data and timing; between responses the data must hold.
    always @(posedge clk) begin
        exp_t e;
        #3;
        if (!rst) begin
            for (int p = 0; p < 2; p++) begin
                if (rsp_v[p]) begin
                    if (expq[p].size() == 0) begin
                        checkOutput($sformatf("unexpected_rsp%0d", p), 32'd1, 32'd0);
                    end else begin
                        e = expq[p].pop_front();
                        checkOutput($sformatf("rsp_data%0d", p), rsp_d[p], e.data);
                        checkOutput($sformatf("rsp_edge%0d", p), cyc, e.due);
                        last_rsp[p] = e.data;
                    end
                end else begin
                    checkOutput($sformatf("rsp_hold%0d", p), rsp_d[p], last_rsp[p]);
                    if (expq[p].size() != 0 && expq[p][0].due <= cyc) begin
                        e = expq[p].pop_front();
                        checkOutput($sformatf("missing_rsp%0d", p), 32'd0, 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        int c;
        logic          r_we;
        logic [AW-1:0] r_addr;
        logic [NB-1:0] r_be;
        logic [DW-1:0] r_wdata;

        modelReset();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = '0;
        #12;
        checkResetOutputs("por");

        // Release reset with a read already waiting.
        @(negedge clk);
        rst = 1'b0;
        c   = cyc;
        waitInit("init", c);
        applyStimulus(1'b0, 8'h00, 4'h0, 32'h0);

        // Full-word writes then back-to-back reads.
        applyStimulus(1'b1, 8'h01, 4'hf, 32'hdeadbeef);
        applyStimulus(1'b1, 8'h02, 4'hf, 32'hcafebabe);
        applyStimulus(1'b0, 8'h01, 4'h0, 32'h0);
        applyStimulus(1'b0, 8'h02, 4'h0, 32'h0);

        // Partial-lane write and an all-lanes-disabled write.
        applyStimulus(1'b1, 8'h01, 4'b0101, 32'h11223344);
        applyStimulus(1'b0, 8'h01, 4'h0, 32'h0);
        applyStimulus(1'b1, 8'h01, 4'b0000, 32'h55667788);
        applyStimulus(1'b0, 8'h01, 4'h0, 32'h0);

        // Four back-to-back reads.
        repeat (4) applyStimulus(1'b0, 8'h02, 4'h0, 32'h0);
        idle(5);

        // Randomised traffic over a small address window so reads hit
        // recently written words, including read-right-after-write.
        repeat (300) begin
            r_we    = 1'($urandom_range(0, 1));
            r_addr  = AW'($urandom_range(0, 15));
            r_be    = NB'($urandom);
            r_wdata = $urandom;
            applyStimulus(r_we, r_addr, r_be, r_wdata);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(5);

        // Soft clear raised while a read is in flight and another is waiting.
        applyStimulus(1'b1, 8'h01, 4'hf, 32'h0badf00d);
        applyStimulus(1'b0, 8'h01, 4'h0, 32'h0);
        c         = cyc;
        clr       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h01;
        #1;
        checkOutput("clr_blocks_ready0", {31'd0, ready[0]}, 32'd0);
        checkOutput("clr_blocks_ready1", {31'd0, ready[1]}, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        modelClear();
        waitInit("clr", c + 1);
        applyStimulus(1'b0, 8'h01, 4'h0, 32'h0);
        applyStimulus(1'b0, 8'h02, 4'h0, 32'h0);
        idle(5);

        // Reset landing right after a read is accepted.
        applyStimulus(1'b1, 8'h03, 4'hf, 32'ha5a5a5a5);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h03;
        #1;
        if (ready[0]) modelAccept(1'b0, 8'h03, 4'h0, 32'h0, cyc + 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        modelReset();
        #1;
        checkResetOutputs("rst_inflight");
        req_valid = 1'b0;
        idle(2);
        rst = 1'b0;

        // Reset again in the middle of the clear sweep.
        idle(100);
        checkOutput("mid_clear_init_done", {31'd0, done[0]}, 32'd0);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkResetOutputs("rst_midclear");
        @(negedge clk);
        rst = 1'b0;
        c   = cyc;
        waitInit("rst", c);

        applyStimulus(1'b0, 8'h01, 4'h0, 32'h0);
        applyStimulus(1'b0, 8'h03, 4'h0, 32'h0);
        repeat (60) begin
            r_we    = 1'($urandom_range(0, 1));
            r_addr  = AW'($urandom_range(0, 7));
            r_be    = NB'($urandom);
            r_wdata = $urandom;
            applyStimulus(r_we, r_addr, r_be, r_wdata);
        end
        idle(6);

        checkOutput("drained_lat1", expq[0].size(), 32'd0);
        checkOutput("drained_lat3", expq[1].size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/byte_enable_memory.md
Name: byte_enable_memory

Overview:
- Parameterised single-port synchronous RAM with per-byte write enables, valid/ready request handshake and configurable read pipeline latency.
- Hardware zero-initialises the whole array after reset and on a soft-clear request.
- Next-generation data memory for the processor datapath; it replaces the fixed 8-bit-address / 32-bit-data array.
- Serves load/store traffic from the core's memory stage.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, word address width; DEPTH = 2**ADDR_WIDTH words.
- READ_LATENCY, 1, cycles from accepted read to rsp_valid; legal range 1..4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- clr  input  1  synchronous soft-clear request (one-cycle pulse)
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- req_we  input  1  1 = write, 0 = read
- req_addr  input  ADDR_WIDTH  word address
- req_be  input  DATA_WIDTH/8  byte-lane write enables; bit i selects bits [8i+7:8i]
- req_wdata  input  DATA_WIDTH  write data
- rsp_valid  output  1  read data valid (one-cycle pulse per read)
- rsp_rdata  output  DATA_WIDTH  read data
- init_done  output  1  high once array clearing is complete

Behaviour:
- Reset (asynchronous, any time):
  - State goes to CLEAR; clear address counter = 0.
  - rsp_valid = 0, rsp_rdata = 0, init_done = 0, req_ready = 0.
  - Read pipeline flushed; in-flight reads produce no response.
- State machine, two states:
  - CLEAR: writes 0 to address clr_cnt each cycle, clr_cnt increments. The write at clr_cnt = DEPTH-1 moves to READY on the same edge; the counter wraps to 0. Takes exactly DEPTH cycles. req_ready = 0 and init_done = 0 throughout.
  - READY: init_done = 1. A clr pulse moves to CLEAR next edge, clears init_done and restarts clr_cnt at 0.
- req_ready = (state == READY) && !clr, combinational.
  - clr asserted together with req_valid: clear wins; request not accepted; requester holds it.
- Handshake:
  - Transfer occurs on an edge where req_valid && req_ready; one request per cycle, no internal queue.
  - req_valid may be driven before ready; requester holds all request fields stable until accepted.
- Write:
  - On the accepting edge, each lane with req_be[i] = 1 takes req_wdata lane i; other lanes keep their value.
  - req_be = 0 is a legal no-op.
  - Writes produce no response.
- Read:
  - Data captured from the array on the accepting edge.
  - rsp_valid is high for exactly one cycle, READ_LATENCY cycles after the accepting edge; rsp_rdata is valid in that cycle.
  - Back-to-back reads give back-to-back responses in order; full throughput.
  - rsp_rdata holds its last value while rsp_valid = 0.
- Ordering:
  - A read accepted the cycle after a write to the same address returns the new data.
  - No same-cycle read/write conflict exists (single port).
- Reads already in flight when clr is accepted still complete with their pre-clear data.
- Addressing: every req_addr value is in range (DEPTH = 2**ADDR_WIDTH); no wrap or error handling.

Test Plan:
- Release rst, req_valid = 1 read addr 0x00 -> req_ready = 0 for 256 cycles; init_done rises at cycle 256; then read accepted, rsp_valid after 1 cycle, rsp_rdata = 0x00000000.
- Write 0x01 = 0xdeadbeef (be = 1111), write 0x02 = 0xcafebabe, read 0x01, read 0x02 back-to-back -> rsp_valid on two consecutive cycles, data 0xdeadbeef then 0xcafebabe.
- Write 0x01 with be = 0101, wdata = 0x11223344 over 0xdeadbeef -> read returns 0xde22be44; be = 0000 write leaves it unchanged.
- READ_LATENCY = 3: read 0x02 issued at cycle t -> rsp_valid only at t+3; four back-to-back reads give four consecutive pulses.
- Pulse clr while req_valid = 1, with one read in flight -> request not accepted that cycle; in-flight read returns old data; init_done low for 256 cycles; afterwards 0x01 reads 0x00000000.
- Assert rst mid-CLEAR (cycle 100) and during a pending read -> outputs go to reset values immediately; no rsp_valid pulse; clear restarts and init_done rises 256 cycles after rst deasserts.
